// File: rtl/ram_bus_master_if.sv
// Request/response and RAM-bus signals of ram_bus_master, grouped for port connection.
// Latency: none, wires only.
// Backpressure: ReqReady from the master gates ReqValid; responses are never stalled.
// Ports (master view):
//   in  ReqValid, ReqOp, ReqAddr, ReqData
//   out ReqReady, RespValid, RespData, Address, CS, WE_n
// The shared Data bus is a plain inout on the module, kept out of this interface.
interface ram_bus_master_if #(
    parameter int AddressSize = 16,
    parameter int DataSize    = 8
);
    logic                   ReqValid;
    logic                   ReqReady;
    logic [1:0]             ReqOp;
    logic [AddressSize-1:0] ReqAddr;
    logic [DataSize-1:0]    ReqData;
    logic                   RespValid;
    logic [DataSize-1:0]    RespData;
    logic [AddressSize-1:0] Address;
    logic                   CS;
    logic                   WE_n;

    modport master (
        input  ReqValid, ReqOp, ReqAddr, ReqData,
        output ReqReady, RespValid, RespData, Address, CS, WE_n
    );

    modport slave (
        output ReqValid, ReqOp, ReqAddr, ReqData,
        input  ReqReady, RespValid, RespData, Address, CS, WE_n
    );
endinterface

// File: rtl/ram_bus_master.sv
// Initiator for a CS/WE_n single-port RAM: READ, WRITE, INC, DEC, one request at a time.
// Latency: accept to RespValid is 1 cycle for READ/WRITE, 2 cycles for INC/DEC.
// Backpressure: ReqReady is high only when idle; requests seen while busy are dropped.
// Ports:
//   Clk, Rst_n : clock and asynchronous active-low reset
//   bus        : ram_bus_master_if.master (request, response, Address/CS/WE_n)
//   Data       : shared RAM data bus, driven only while writing
module ram_bus_master #(
    parameter int AddressSize = 16,
    parameter int DataSize    = 8
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    ram_bus_master_if.master      bus,
    inout  wire  [DataSize-1:0]   Data
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10
    } state_t;

    state_t                 state_q;
    logic [AddressSize-1:0] addr_q;
    logic [1:0]             op_q;
    logic [DataSize-1:0]    wr_q;      // value placed on Data during WR
    logic                   cs_q;
    logic                   we_n_q;
    logic                   oe_q;      // Data output enable
    logic                   rvld_q;
    logic [DataSize-1:0]    rdat_q;

    // Every bus-facing output comes straight from a flop; reset clears cs_q
    // asynchronously, so a write in progress is abandoned before its edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= OP_READ;
            wr_q    <= '0;
            cs_q    <= 1'b0;
            we_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            rvld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.ReqValid) begin
                        addr_q <= bus.ReqAddr;
                        op_q   <= bus.ReqOp;
                        wr_q   <= bus.ReqData;
                        cs_q   <= 1'b1;
                        if (bus.ReqOp == OP_WRITE) begin
                            state_q <= S_WR;
                            we_n_q  <= 1'b0;
                            oe_q    <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (op_q == OP_READ) begin
                        state_q <= S_IDLE;
                        cs_q    <= 1'b0;
                        rvld_q  <= 1'b1;
                        rdat_q  <= Data;
                    end else begin
                        // Read-modify-write: CS and Address stay put, only the
                        // direction flips for the write-back cycle.
                        state_q <= S_WR;
                        we_n_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        wr_q    <= (op_q == OP_INC) ? Data + DataSize'(1)
                                                    : Data - DataSize'(1);
                    end
                end
                S_WR: begin
                    state_q <= S_IDLE;
                    cs_q    <= 1'b0;
                    we_n_q  <= 1'b1;
                    oe_q    <= 1'b0;
                    rvld_q  <= 1'b1;
                    rdat_q  <= wr_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    cs_q    <= 1'b0;
                    we_n_q  <= 1'b1;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReqReady  = (state_q == S_IDLE);
    assign bus.RespValid = rvld_q;
    assign bus.RespData  = rdat_q;
    assign bus.Address   = addr_q;
    assign bus.CS        = cs_q;
    assign bus.WE_n      = we_n_q;
    assign Data          = oe_q ? wr_q : {DataSize{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural RAM on the bus, a transaction-level
// reference model with a per-cycle compare process, plus directed literal checks.
module tb_ram_bus_master;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, INC = 2'b10, DEC = 2'b11;

    logic Clk = 1'b0;
    logic Rst_n = 1'b1;
    wire [DW-1:0] Data;

    ram_bus_master_if #(.AddressSize(AW), .DataSize(DW)) bus();

    ram_bus_master #(.AddressSize(AW), .DataSize(DW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus),
        .Data  (Data)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        case (a)
            'h20: v = 8'hFF;
            'h21: v = 8'h00;
            'h40: v = 8'h11;
            'h50: v = 8'h0A;
            'h60: v = 8'hC3;
            default: v = 8'(a) ^ 8'h5A;
        endcase
        return v;
    endfunction

    // ---------------- behavioural RAM per the bus contract ----------------
    logic [7:0] mem [0:65535];
    bit mem_loaded = 0;
    assign Data = (bus.CS && bus.WE_n) ? mem[bus.Address] : 8'hzz;
    always @(posedge Clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
            mem_loaded <= 1;
        end else if (bus.CS && !bus.WE_n) begin
            mem[bus.Address] <= Data;
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  ref_mem [0:65535];
    bit          ref_loaded = 0;
    int          cyc = 0;
    bit          m_busy = 0, m_acc_flag = 0, m_rvld = 0;
    logic [1:0]  m_op = 2'b00;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_res = '0, m_rdat = '0;
    int          m_acc = 0, m_done = 0;
    int          acc_q[$];

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            if (!ref_loaded) begin
                for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
                ref_loaded = 1;
            end
            m_busy = 0; m_rvld = 0; m_rdat = 8'h00; m_acc_flag = 0;
            acc_q.delete();
        end else begin
            cyc++;
            m_acc_flag = 0;
            m_rvld = 0;
            if (m_busy && cyc == m_done) begin
                m_busy = 0;
                m_rvld = 1;
                m_rdat = m_res;
                if (m_op != RD) ref_mem[m_addr] = m_res;
            end else if (!m_busy && bus.ReqValid) begin
                m_busy = 1;
                m_acc_flag = 1;
                m_op = bus.ReqOp;
                m_addr = bus.ReqAddr;
                m_acc = cyc;
                m_done = cyc + ((bus.ReqOp == INC || bus.ReqOp == DEC) ? 2 : 1);
                case (bus.ReqOp)
                    RD:  m_res = ref_mem[bus.ReqAddr];
                    WR:  m_res = bus.ReqData;
                    INC: m_res = ref_mem[bus.ReqAddr] + 8'd1;
                    default: m_res = ref_mem[bus.ReqAddr] - 8'd1;
                endcase
                acc_q.push_back(cyc);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int rsp_cyc[$];
    logic [7:0] rsp_dat[$];
    bit wr_ph;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            chk("rst_CS", bus.CS, 0);
            chk("rst_WE_n", bus.WE_n, 1);
            chk("rst_RespValid", bus.RespValid, 0);
            chk("rst_RespData", bus.RespData, 0);
            chk("rst_Address", bus.Address, 0);
        end else begin
            wr_ph = m_busy && (m_op == WR || ((m_op == INC || m_op == DEC) && cyc == m_acc + 1));
            chk("ReqReady", bus.ReqReady, !m_busy);
            chk("CS", bus.CS, m_busy);
            chk("WE_n", bus.WE_n, !wr_ph);
            chk("RespValid", bus.RespValid, m_rvld);
            chk("RespData", bus.RespData, m_rdat);
            if (m_busy) chk("Address", bus.Address, m_addr);
            if (wr_ph) chk("Data_drive", Data, m_res);
            if (bus.RespValid) begin
                rsp_cyc.push_back(cyc);
                rsp_dat.push_back(bus.RespData);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        bus.ReqValid = 1'b1;
        bus.ReqOp    = op;
        bus.ReqAddr  = a;
        bus.ReqData  = d;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk);
            #1;
            if (m_acc_flag) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: op %0d addr %0h not accepted in 10 cycles", op, a);
    endtask

    task automatic idle();
        bus.ReqValid = 1'b0;
    endtask

    int last_rsp = 0;

    // Literal response check: data, latency from accept edge, and optional
    // zero-bubble check against the previous response cycle.
    task automatic check_resp(input string nm, input logic [7:0] exp_d,
                              input int exp_lat, input bit b2b);
        int a, c;
        logic [7:0] d;
        for (int k = 0; k < 20 && rsp_dat.size() == 0; k++) @(negedge Clk);
        if (rsp_dat.size() == 0 || acc_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no response within 20 cycles", nm);
            return;
        end
        a = acc_q.pop_front();
        c = rsp_cyc.pop_front();
        d = rsp_dat.pop_front();
        chk({nm, "_data"}, d, exp_d);
        chk({nm, "_lat"}, c - a, exp_lat);
        if (b2b) chk({nm, "_gap"}, a, last_rsp + 1);
        last_rsp = c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ReqValid = 1'b0;
        bus.ReqOp    = 2'b00;
        bus.ReqAddr  = '0;
        bus.ReqData  = '0;
        #1 Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        chk("ready_after_reset", bus.ReqReady, 1);
        @(posedge Clk);
        #1;

        // WRITE then READ of 0x10
        send(WR, 16'h0010, 8'h5A);
        send(RD, 16'h0010, 8'h00);
        idle();
        check_resp("wr10", 8'h5A, 1, 0);
        check_resp("rd10", 8'h5A, 1, 1);

        // INC wraps 0xFF->0x00, DEC wraps 0x00->0xFF
        send(INC, 16'h0020, 8'h99);
        send(DEC, 16'h0021, 8'h99);
        send(RD, 16'h0020, 8'h00);
        send(RD, 16'h0021, 8'h00);
        idle();
        check_resp("inc20", 8'h00, 2, 0);
        check_resp("dec21", 8'hFF, 2, 1);
        check_resp("rd20", 8'h00, 1, 1);
        check_resp("rd21", 8'hFF, 1, 1);

        // back-to-back sequence on 0x30
        send(WR, 16'h0030, 8'h07);
        send(RD, 16'h0030, 8'h00);
        send(INC, 16'h0030, 8'h00);
        send(RD, 16'h0030, 8'h00);
        idle();
        check_resp("b2b_wr", 8'h07, 1, 0);
        check_resp("b2b_rd", 8'h07, 1, 1);
        check_resp("b2b_inc", 8'h08, 2, 1);
        check_resp("b2b_rd2", 8'h08, 1, 1);

        // request presented while busy is ignored
        send(INC, 16'h0050, 8'h00);
        bus.ReqOp   = WR;
        bus.ReqAddr = 16'h0060;
        bus.ReqData = 8'hEE;
        @(posedge Clk); #1;
        bus.ReqOp   = DEC;
        bus.ReqAddr = 16'h0050;
        @(posedge Clk); #1;
        idle();
        check_resp("inc50", 8'h0B, 2, 0);
        send(RD, 16'h0060, 8'h00);
        send(RD, 16'h0050, 8'h00);
        idle();
        check_resp("rd60_untouched", 8'hC3, 1, 0);
        check_resp("rd50", 8'h0B, 1, 1);

        // reset during the write-back of an INC leaves the cell unchanged
        send(INC, 16'h0040, 8'h00);
        idle();
        @(posedge Clk); #2;
        chk("inc40_in_write", bus.WE_n, 0);
        Rst_n = 1'b0;
        #1;
        chk("async_CS_drop", bus.CS, 0);
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        chk("ready_after_midreset", bus.ReqReady, 1);
        @(posedge Clk); #1;
        send(RD, 16'h0040, 8'h00);
        idle();
        check_resp("rd40_after_reset", 8'h11, 1, 0);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
